// File: rtl/multiword_add_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package multiword_add_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation select encoding, as carried on the sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/word_adder.sv
// N-bit ripple-carry adder slice. Exposes the carry into the MSB so the
// caller can form two's-complement overflow as c_msb ^ co.
module word_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb
);

  // carry_chain[i] is the carry into bit i; carry_chain[N] leaves the slice.
  logic [N:0] carry_chain;

  assign carry_chain[0] = cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      logic half_sum;
      assign half_sum            = x[gi] ^ y[gi];
      assign s[gi]               = half_sum ^ carry_chain[gi];
      assign carry_chain[gi + 1] = (x[gi] & y[gi]) | (half_sum & carry_chain[gi]);
    end
  endgenerate

  assign co    = carry_chain[N];
  assign c_msb = carry_chain[N-1];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Wide (N*WORDS-bit) add/subtract built from one N-bit slice, processed
// least-significant word first with the carry held in a register between words.
module multiword_add_ctrl
  import multiword_add_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t          state_reg;
  state_t          state_next;
  logic [IW-1:0]   idx_reg;
  logic            carry_reg;
  logic            op_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            cout_reg;
  logic            ovf_reg;

  logic            start_accept;
  logic            run_active;
  logic            last_word;

  logic [N-1:0]    a_words [WORDS];
  logic [N-1:0]    b_words [WORDS];
  logic [N-1:0]    slice_x;
  logic [N-1:0]    slice_y;
  logic [N-1:0]    slice_s;
  logic            slice_co;
  logic            slice_c_msb;

  // Split the latched operands into per-word views for the slice mux.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
      assign a_words[gi] = a_reg[gi*N +: N];
      assign b_words[gi] = b_reg[gi*N +: N];
    end
  endgenerate

  assign start_accept = (state_reg == IDLE) && start;
  assign run_active   = (state_reg == RUN);
  assign last_word    = run_active && (idx_reg == IW'(WORDS - 1));

  // Subtraction feeds the inverted B word; the +1 enters as the initial carry.
  assign slice_x = a_words[idx_reg];
  assign slice_y = (op_reg == OP_SUB) ? ~b_words[idx_reg] : b_words[idx_reg];

  word_adder #(
    .N (N)
  ) u_word_adder (
    .x     (slice_x),
    .y     (slice_y),
    .cin   (carry_reg),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_c_msb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_word) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, word index, inter-word carry and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      op_reg    <= OP_ADD;
      a_reg     <= '0;
      b_reg     <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (start_accept) begin
      a_reg     <= a;
      b_reg     <= b;
      op_reg    <= sub;
      idx_reg   <= '0;
      carry_reg <= sub;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (run_active) begin
      carry_reg <= slice_co;
      idx_reg   <= last_word ? '0 : IW'(idx_reg + 1'b1);
      if (last_word) begin
        cout_reg <= slice_co;
        ovf_reg  <= slice_c_msb ^ slice_co;
      end
    end
  end

  // One result register per word; only the word being processed is written.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_sum
      logic [N-1:0] word_reg;

      // Capture the slice sum when this word is the current index.
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (run_active && (idx_reg == IW'(gi))) begin
          word_reg <= slice_s;
        end
      end

      assign sum[gi*N +: N] = word_reg;
    end
  endgenerate

  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench: directed cases, start-spam/reset handshake checks,
// random regression against a plain-arithmetic reference, and standalone
// word_adder checks for N=8 and N=16.
module tb_multiword_add_ctrl;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
  } res_t;

  logic clk;
  logic rst;

  // Index 0: N=8, WORDS=4. Index 1: N=16, WORDS=2. Both are 32 bits wide.
  logic        st    [2];
  logic        sb    [2];
  logic [31:0] av    [2];
  logic [31:0] bv    [2];
  logic        busyv [2];
  logic        donev [2];
  logic [31:0] sumv  [2];
  logic        coutv [2];
  logic        ovfv  [2];

  logic [7:0]  wx8, wy8, ws8;
  logic        wc8, wco8, wcm8;
  logic [15:0] wx16, wy16, ws16;
  logic        wc16, wco16, wcm16;

  int total = 0;
  int bad   = 0;

  multiword_add_ctrl #(.N(8), .WORDS(4)) dut8 (
    .clk (clk), .rst (rst), .start (st[0]), .sub (sb[0]),
    .a (av[0]), .b (bv[0]), .busy (busyv[0]), .done (donev[0]),
    .sum (sumv[0]), .cout (coutv[0]), .ovf (ovfv[0])
  );

  multiword_add_ctrl #(.N(16), .WORDS(2)) dut16 (
    .clk (clk), .rst (rst), .start (st[1]), .sub (sb[1]),
    .a (av[1]), .b (bv[1]), .busy (busyv[1]), .done (donev[1]),
    .sum (sumv[1]), .cout (coutv[1]), .ovf (ovfv[1])
  );

  word_adder #(.N(8)) wa8 (
    .x (wx8), .y (wy8), .cin (wc8), .s (ws8), .co (wco8), .c_msb (wcm8)
  );

  word_adder #(.N(16)) wa16 (
    .x (wx16), .y (wy16), .cin (wc16), .s (ws16), .co (wco16), .c_msb (wcm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: W-bit modular arithmetic plus signed-range overflow test.
  function automatic res_t ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    res_t        r;
    logic [32:0] t;
    longint      sr;
    if (sub) begin
      t  = {1'b0, a} + {1'b0, ~b} + 33'd1;
      sr = longint'($signed(a)) - longint'($signed(b));
    end else begin
      t  = {1'b0, a} + {1'b0, b};
      sr = longint'($signed(a)) + longint'($signed(b));
    end
    r.s = t[31:0];
    r.c = t[32];
    r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  // One directed operation; latency counts clock edges from the accepting edge.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic ev, input int elat);
    int lat;
    st[w] = 1'b1; av[w] = a; bv[w] = b; sb[w] = sub;
    @(posedge clk); #1;
    st[w] = 1'b0;
    lat = 1;
    chk("accept_busy", 64'(busyv[w]), 64'd1);
    chk("accept_clr_cout", 64'(coutv[w]), 64'd0);
    chk("accept_clr_ovf", 64'(ovfv[w]), 64'd0);
    while (!donev[w] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("sum", 64'(sumv[w]), 64'(es));
    chk("cout", 64'(coutv[w]), 64'(ec));
    chk("ovf", 64'(ovfv[w]), 64'(ev));
    $display("op dut%0d %s a=%08h b=%08h sum=%08h cout=%0b ovf=%0b lat=%0d",
             w, sub ? "sub" : "add", a, b, sumv[w], coutv[w], ovfv[w], lat);
    @(posedge clk); #1;
    chk("done_single", 64'(donev[w]), 64'd0);
    chk("idle_after", 64'(busyv[w]), 64'd0);
  endtask

  // Random start stream; acceptance predicted from the rule that a new
  // operation can begin only WORDS+2 cycles after the previous acceptance.
  task automatic stream(input int w, input int ncyc, input int pct);
    int   words;
    int   free_at;
    int   last_t;
    int   done_edge;
    res_t pend;
    words     = (w == 0) ? 4 : 2;
    free_at   = 0;
    last_t    = -1000;
    done_edge = -1;
    pend      = '{s: 32'd0, c: 1'b0, v: 1'b0};
    for (int k = 0; k < ncyc; k++) begin
      st[w] = (k < ncyc - words - 2) && ($urandom_range(99) < pct);
      av[w] = $urandom;
      bv[w] = $urandom;
      sb[w] = 1'($urandom_range(1));
      if (($urandom_range(7) == 0)) av[w] = 32'h8000_0000;
      if (($urandom_range(7) == 0)) bv[w] = 32'hFFFF_FFFF;
      @(posedge clk);
      if (st[w] && k >= free_at) begin
        pend      = ref_op(av[w], bv[w], sb[w]);
        done_edge = k + words;
        free_at   = k + words + 2;
        last_t    = k;
      end
      #1;
      chk("stream_busy", 64'(busyv[w]), 64'((k >= last_t) && (k <= last_t + words)));
      if (k == done_edge) begin
        chk("stream_done", 64'(donev[w]), 64'd1);
        chk("stream_sum", 64'(sumv[w]), 64'(pend.s));
        chk("stream_cout", 64'(coutv[w]), 64'(pend.c));
        chk("stream_ovf", 64'(ovfv[w]), 64'(pend.v));
        $display("stream dut%0d cycle=%0d sum=%08h cout=%0b ovf=%0b exp=%08h/%0b/%0b",
                 w, k, sumv[w], coutv[w], ovfv[w], pend.s, pend.c, pend.v);
      end else begin
        chk("stream_no_done", 64'(donev[w]), 64'd0);
      end
    end
    st[w] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin
      st[w] = 1'b0; sb[w] = 1'b0; av[w] = '0; bv[w] = '0;
    end
    wx8 = '0; wy8 = '0; wc8 = 1'b0;
    wx16 = '0; wy16 = '0; wc16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int w = 0; w < 2; w++) begin
      chk("rst_busy", 64'(busyv[w]), 64'd0);
      chk("rst_done", 64'(donev[w]), 64'd0);
      chk("rst_sum", 64'(sumv[w]), 64'd0);
      chk("rst_cout", 64'(coutv[w]), 64'd0);
      chk("rst_ovf", 64'(ovfv[w]), 64'd0);
    end

    // Directed cases, N=8 WORDS=4.
    run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 5);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 5);
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 5);
    run_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 5);
    run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 5);

    // Directed case, N=16 WORDS=2.
    run_op(1, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 32'h0002_0000, 1'b0, 1'b0, 3);
    run_op(1, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 3);

    // Standalone slices against x+y+cin; c_msb from the low N-1 bits.
    for (int i = 0; i < 24; i++) begin
      logic [8:0]  e8;
      logic [7:0]  lo8;
      logic [16:0] e16;
      logic [15:0] lo16;
      wx8 = 8'($urandom); wy8 = 8'($urandom); wc8 = 1'($urandom_range(1));
      wx16 = 16'($urandom); wy16 = 16'($urandom); wc16 = 1'($urandom_range(1));
      if (i == 0) begin wx8 = 8'hFF; wy8 = 8'h00; wc8 = 1'b1; wx16 = 16'hFFFF; wy16 = 16'h0000; wc16 = 1'b1; end
      if (i == 1) begin wx8 = 8'h7F; wy8 = 8'h00; wc8 = 1'b1; wx16 = 16'h7FFF; wy16 = 16'h0000; wc16 = 1'b1; end
      #1;
      e8   = 9'(wx8) + 9'(wy8) + 9'(wc8);
      lo8  = 8'(wx8[6:0]) + 8'(wy8[6:0]) + 8'(wc8);
      e16  = 17'(wx16) + 17'(wy16) + 17'(wc16);
      lo16 = 16'(wx16[14:0]) + 16'(wy16[14:0]) + 16'(wc16);
      chk("wa8_sum", 64'({wco8, ws8}), 64'(e8));
      chk("wa8_cmsb", 64'(wcm8), 64'(lo8[7]));
      chk("wa16_sum", 64'({wco16, ws16}), 64'(e16));
      chk("wa16_cmsb", 64'(wcm16), 64'(lo16[15]));
      $display("slice x8=%02h y8=%02h c=%0b -> %0b_%02h | x16=%04h y16=%04h c=%0b -> %0b_%04h",
               wx8, wy8, wc8, wco8, ws8, wx16, wy16, wc16, wco16, ws16);
    end

    // Reset after two RUN cycles: everything clears, no done afterwards.
    st[0] = 1'b1; av[0] = 32'h1234_5678; bv[0] = 32'h1111_1111; sb[0] = 1'b0;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 64'(busyv[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst_busy", 64'(busyv[0]), 64'd0);
    chk("midrun_rst_sum", 64'(sumv[0]), 64'd0);
    chk("midrun_rst_done", 64'(donev[0]), 64'd0);
    chk("midrun_rst_cout", 64'(coutv[0]), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", 64'(donev[0]), 64'd0);
    end
    $display("reset mid-run dut0 busy=%0b sum=%08h", busyv[0], sumv[0]);

    // Start held high every cycle, then random regressions.
    stream(0, 30, 100);
    stream(1, 20, 100);
    stream(0, 300, 50);
    stream(1, 300, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
